// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART transmitter:
//   - state_t     : frame sequencer state encodings
//   - PAR_EVEN/ODD: parity-type selector values
//   - LINE_IDLE   : line level while idle and during stop bits
//   - parity_bit(): parity bit from a payload XOR-reduction and parity type
// -----------------------------------------------------------------------------
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP_1 = 3'd4,
    STOP_2 = 3'd5
  } state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

  function automatic logic parity_bit(input logic xor_red, input logic par_typ);
    logic p;
    case (par_typ)
      PAR_EVEN: p = xor_red;
      PAR_ODD:  p = ~xor_red;
      default:  p = xor_red;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Loadable payload shift register plus bit counter.
//   CLK       : clock
//   RST       : asynchronous, active-low reset
//   load      : capture load_data and rearm the bit counter
//   shift_en  : advance to the next payload bit
//   load_data : payload (DATA_WIDTH bits)
//   ser_data  : the payload bit that goes on the line next
//   ser_done  : bit counter has reached the last payload bit
// Parameters: DATA_WIDTH (5..16), MSB_FIRST (0 = LSB first, 1 = MSB first).
// -----------------------------------------------------------------------------
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  ser_data,
  output logic                  ser_done
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [CNT_W-1:0]      cnt_reg;

  // ser_data always presents the bit that will be registered onto the line
  // at the next advance, so the register shifts one step ahead of the line:
  // the first shift happens when leaving START. The counter is loaded with
  // all-ones so that first shift wraps it to 0, making it equal to the index
  // of the payload bit currently on the line throughout DATA.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shift_next = {shift_reg[DATA_WIDTH-2:0], 1'b0};
      assign ser_data   = shift_reg[DATA_WIDTH-1];
    end else begin : g_lsb_first
      assign shift_next = {1'b0, shift_reg[DATA_WIDTH-1:1]};
      assign ser_data   = shift_reg[0];
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (load) begin
      shift_reg <= load_data;
      cnt_reg   <= '1;
    end else if (shift_en) begin
      shift_reg <= shift_next;
      cnt_reg   <= cnt_reg + 1'b1;
    end
  end

  // Only meaningful while in DATA; the all-ones preload may alias the last
  // index during START, where the sequencer ignores it.
  assign ser_done = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_ctrl
// UART transmitter: frame sequencing, serialisation, parity and line mux.
// Frame = start(0), DATA_WIDTH payload bits, optional parity, 1 or 2 stop(1).
// Back-to-back frames start straight from the final stop bit with no gap.
//   CLK        : transmit clock (one bit period per cycle, or per Tick)
//   RST        : asynchronous, active-low reset
//   P_DATA     : payload, latched on acceptance
//   Data_Valid : payload request, accepted in IDLE or the final stop bit
//   PAR_EN     : insert a parity bit
//   PAR_TYP    : 0 = even parity, 1 = odd parity
//   STOP2      : 0 = one stop bit, 1 = two stop bits
//   Tick       : baud strobe, present only with UART_TX_BAUD_TICK_EN defined
//   TX_OUT     : serial line (registered)
//   Busy       : frame in progress (registered)
// Optional build macro: UART_TX_BAUD_TICK_EN
// -----------------------------------------------------------------------------
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
`ifdef UART_TX_BAUD_TICK_EN
  input  logic                  Tick,
`endif
  output logic                  TX_OUT,
  output logic                  Busy
);

  state_t state_reg, state_next;
  logic   tx_reg, tx_next;
  logic   busy_reg, busy_next;
  logic   par_en_reg, stop2_reg, par_bit_reg;

  logic   load, shift_en, ser_data, ser_done;
  logic   advance, final_stop;

`ifdef UART_TX_BAUD_TICK_EN
  assign advance = Tick;
`else
  assign advance = 1'b1;
`endif

  // The last stop bit of the frame is where a follow-on frame may be accepted.
  assign final_stop = (state_reg == STOP_2) || ((state_reg == STOP_1) && !stop2_reg);

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .MSB_FIRST  (MSB_FIRST)
  ) u_serializer (
    .CLK       (CLK),
    .RST       (RST),
    .load      (load),
    .shift_en  (shift_en),
    .load_data (P_DATA),
    .ser_data  (ser_data),
    .ser_done  (ser_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg   <= IDLE;
      tx_reg      <= LINE_IDLE;
      busy_reg    <= 1'b0;
      par_en_reg  <= 1'b0;
      stop2_reg   <= 1'b0;
      par_bit_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      if (load) begin
        par_en_reg <= PAR_EN;
        stop2_reg  <= STOP2;
        // Parity is resolved at acceptance; the payload is frozen from here on.
        par_bit_reg <= parity_bit(^P_DATA, PAR_TYP);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    tx_next    = tx_reg;
    busy_next  = busy_reg;
    load       = 1'b0;
    shift_en   = 1'b0;

    case (state_reg)
      IDLE: begin
        tx_next   = LINE_IDLE;
        busy_next = 1'b0;
        if (Data_Valid) begin
          state_next = START;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
          load       = 1'b1;
        end
      end

      START: begin
        if (advance) begin
          state_next = DATA;
          tx_next    = ser_data;
          shift_en   = 1'b1;
        end
      end

      DATA: begin
        if (advance) begin
          if (!ser_done) begin
            tx_next  = ser_data;
            shift_en = 1'b1;
          end else if (par_en_reg) begin
            state_next = PARITY;
            tx_next    = par_bit_reg;
          end else begin
            state_next = STOP_1;
            tx_next    = LINE_IDLE;
          end
        end
      end

      PARITY: begin
        if (advance) begin
          state_next = STOP_1;
          tx_next    = LINE_IDLE;
        end
      end

      STOP_1, STOP_2: begin
        if (advance) begin
          if (!final_stop) begin
            state_next = STOP_2;
            tx_next    = LINE_IDLE;
          end else if (Data_Valid) begin
            state_next = START;
            tx_next    = 1'b0;
            busy_next  = 1'b1;
            load       = 1'b1;
          end else begin
            state_next = IDLE;
            tx_next    = LINE_IDLE;
            busy_next  = 1'b0;
          end
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = LINE_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign TX_OUT = tx_reg;
  assign Busy   = busy_reg;

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
Parametrised next-generation UART transmitter. It merges frame sequencing, serialisation, parity generation and output-bit selection into one block.
- Adds configurable data width, even/odd parity, 1 or 2 stop bits, LSB/MSB-first order, and back-to-back frames with no idle gap.
- Sits between the system-side TX FIFO read port and the TX pin, in the UART TX clock domain.

Parameters:
DATA_WIDTH, 8, payload bits per frame; legal range 5..16.
MSB_FIRST, 0, 0 = payload sent LSB first; 1 = MSB first.

Ports:
CLK  input  1  transmit clock; one bit period per CLK cycle (see Optional Feature).
RST  input  1  asynchronous, active-low reset.
P_DATA  input  DATA_WIDTH  parallel payload, sampled on acceptance.
Data_Valid  input  1  payload request; accepted per the handshake below.
PAR_EN  input  1  1 = insert a parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
STOP2  input  1  0 = one stop bit, 1 = two stop bits.
TX_OUT  output  1  serial line, registered.
Busy  output  1  frame in progress, registered.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE; TX_OUT = 1; Busy = 0.
  - Shift register, bit counter and latched configuration cleared.
  - Reset mid-frame aborts the frame; the line returns to 1 immediately (asynchronously).
- States: IDLE, START, DATA, PARITY, STOP_1, STOP_2. Encodings come from the package.
- Acceptance: Data_Valid = 1 sampled at a rising edge while in IDLE, or in the final stop-bit state.
  - On that edge: P_DATA, PAR_EN, PAR_TYP and STOP2 are latched, and the next state is START.
  - Data_Valid in any other state is ignored; no queueing, no error.
- Output timing: TX_OUT and Busy are registered and updated at the same edge as the state, so they are valid for the whole cycle the state occupies.
  - START: TX_OUT = 0, Busy = 1, for 1 cycle.
  - DATA: DATA_WIDTH cycles, one payload bit per cycle, in the order set by MSB_FIRST. Bit counter width is $clog2(DATA_WIDTH). Exit when count = DATA_WIDTH-1.
  - PARITY: entered only if latched PAR_EN = 1; 1 cycle.
    - Even parity: TX_OUT = XOR-reduction of the latched payload.
    - Odd parity: TX_OUT = inverse of that XOR-reduction.
  - STOP_1: TX_OUT = 1, 1 cycle. Goes to STOP_2 if latched STOP2 = 1, else the frame ends.
  - STOP_2: TX_OUT = 1, 1 cycle.
- Frame end (final stop-bit state):
  - If Data_Valid = 1, go directly to START. Busy stays 1 and there is no idle cycle.
  - Otherwise go to IDLE: Busy = 0, TX_OUT = 1.
- Frame length in cycles = 1 + DATA_WIDTH + PAR_EN + 1 + STOP2.
- Configuration inputs changing mid-frame have no effect on the current frame.
- Illegal or unused state encodings recover to IDLE with TX_OUT = 1 and Busy = 0.

Optional Feature:
Macro: UART_TX_BAUD_TICK_EN
- Defined:
  - Adds input port Tick (1 bit), a one-CLK-wide baud-rate strobe.
  - The state, bit counter and shift register advance only on edges where Tick = 1, so each bit is held until the next Tick.
  - Acceptance in IDLE ignores Tick. In the final stop-bit state, acceptance requires Tick = 1.
  - START begins at the accepting edge and lasts until the first subsequent Tick.
- Undefined: no Tick port; every CLK cycle is one bit period, as above.

Decomposition:
- Package uart_tx_pkg:
  - state typedef and encodings.
  - Parity-type constants PAR_EVEN = 0, PAR_ODD = 1.
  - Idle/stop line level constant (1).
- Sub-module uart_tx_serializer:
  - Loadable shift register plus bit counter, parametrised by DATA_WIDTH and MSB_FIRST.
  - Inputs: load, shift-enable. Outputs: ser_data, ser_done.
  - Instantiated once; FSM, parity and output mux stay in the top.

Test Plan:
- DATA_WIDTH = 8, LSB first, PAR_EN = 0, STOP2 = 0, P_DATA = 0xA5, single Data_Valid pulse:
  - TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 over 10 cycles.
  - Busy high for exactly 10 cycles, then TX_OUT = 1 and Busy = 0.
- PAR_EN = 1, PAR_TYP = 0, P_DATA = 0x07: parity bit = 1. Repeat with PAR_TYP = 1: parity bit = 0. Both frames 11 cycles.
- STOP2 = 1, PAR_EN = 1, P_DATA = 0x00, PAR_TYP = 0: stop bits 1,1 after parity 0; frame 12 cycles.
- Data_Valid held high across two frames (0x3C then 0xC3):
  - Second START immediately follows the last stop bit; Busy never drops.
  - Data_Valid pulses mid-frame and PAR_EN toggles mid-frame are ignored.
- Reset asserted in DATA bit 3:
  - TX_OUT = 1 and Busy = 0 asynchronously.
  - After release, a new frame 0xFF transmits correctly.
- DATA_WIDTH = 5, MSB_FIRST = 1, P_DATA = 5'b10110: data bits 1,0,1,1,0; frame length 7. With UART_TX_BAUD_TICK_EN and Tick every 4 cycles, each bit lasts 4 cycles.
